pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One pipeline stage register for an in-order MIPS-style pipeline.
// Holds the instruction slot (valid, PC, instruction word, destination
// register, Tnew, payload words, exception code, branch-delay flag) and
// counts the number of cycles in which the stage held a bubble.
//
// Parameters
//   DATA_W           width of one payload word
//   NUM_WORDS        payload word count (ALU result, RD2, HI, LO)
//   TNEW_W           Tnew field width
//   AGE_ON_STALL     1: held Tnew keeps counting down while stalled
//   KEEP_PC_ON_FLUSH 1: a flush still loads PC and BD from upstream
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   stall      hold the stage contents (Tnew may still age)
//   flush      replace the stage contents with a bubble (wins over stall)
//   in_*       upstream slot fields
//   out_*      registered slot fields
//   bubble_cnt saturating count of edges seen with out_valid low
module pipe_stage_reg #(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned NUM_WORDS        = 4,
  parameter int unsigned TNEW_W           = 2,
  parameter int unsigned AGE_ON_STALL     = 1,
  parameter int unsigned KEEP_PC_ON_FLUSH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [31:0]                 in_pc,
  input  logic [31:0]                 in_instr,
  input  logic [4:0]                  in_a3,
  input  logic [TNEW_W-1:0]           in_tnew,
  input  logic [NUM_WORDS*DATA_W-1:0] in_data,
  input  logic [4:0]                  in_exc,
  input  logic                        in_bd,
  output logic                        out_valid,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_instr,
  output logic [4:0]                  out_a3,
  output logic [TNEW_W-1:0]           out_tnew,
  output logic [NUM_WORDS*DATA_W-1:0] out_data,
  output logic [4:0]                  out_exc,
  output logic                        out_bd,
  output logic [15:0]                 bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } action_e;

  action_e                      action;

  logic                         nxt_valid;
  logic [31:0]                  nxt_pc;
  logic [31:0]                  nxt_instr;
  logic [4:0]                   nxt_a3;
  logic [TNEW_W-1:0]            nxt_tnew;
  logic [NUM_WORDS*DATA_W-1:0]  nxt_data;
  logic [4:0]                   nxt_exc;
  logic                         nxt_bd;
  logic [15:0]                  nxt_bubble_cnt;

  // Saturating decrement: Tnew counts down to 0 and stays there.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    tnew_dec = (t != '0) ? t - TNEW_W'(1) : '0;
  endfunction

  // Flush outranks stall, stall outranks load.
  always_comb begin
    action = ACT_LOAD;
    if (flush)      action = ACT_FLUSH;
    else if (stall) action = ACT_STALL;
  end

  always_comb begin
    nxt_valid = out_valid;
    nxt_pc    = out_pc;
    nxt_instr = out_instr;
    nxt_a3    = out_a3;
    nxt_tnew  = out_tnew;
    nxt_data  = out_data;
    nxt_exc   = out_exc;
    nxt_bd    = out_bd;
    unique case (action)
      ACT_FLUSH: begin
        nxt_valid = 1'b0;
        nxt_instr = '0;
        nxt_a3    = '0;
        nxt_tnew  = '0;
        nxt_data  = '0;
        nxt_exc   = '0;
        if (KEEP_PC_ON_FLUSH != 0) begin
          nxt_pc = in_pc;
          nxt_bd = in_bd;
        end else begin
          nxt_pc = '0;
          nxt_bd = 1'b0;
        end
      end
      ACT_STALL: begin
        if (AGE_ON_STALL != 0) nxt_tnew = tnew_dec(out_tnew);
      end
      default: begin
        nxt_valid = in_valid;
        nxt_pc    = in_pc;
        nxt_instr = in_instr;
        nxt_data  = in_data;
        nxt_exc   = in_exc;
        nxt_bd    = in_bd;
        // A non-instruction must never look like a pending register write.
        nxt_a3    = in_valid ? in_a3 : '0;
        nxt_tnew  = in_valid ? tnew_dec(in_tnew) : '0;
      end
    endcase
  end

  // Counts on the registered valid, so it is independent of stall/flush.
  always_comb begin
    nxt_bubble_cnt = bubble_cnt;
    if (!out_valid && bubble_cnt != '1) nxt_bubble_cnt = bubble_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      out_a3     <= '0;
      out_tnew   <= '0;
      out_data   <= '0;
      out_exc    <= '0;
      out_bd     <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      out_valid  <= nxt_valid;
      out_pc     <= nxt_pc;
      out_instr  <= nxt_instr;
      out_a3     <= nxt_a3;
      out_tnew   <= nxt_tnew;
      out_data   <= nxt_data;
      out_exc    <= nxt_exc;
      out_bd     <= nxt_bd;
      bubble_cnt <= nxt_bubble_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default parameters, and
// AGE_ON_STALL=0 / KEEP_PC_ON_FLUSH=0) driven by shared inputs.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic         valid;
    logic         stall;
    logic         flush;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [4:0]   a3;
    logic [1:0]   tnew;
    logic [127:0] data;
    logic [4:0]   exc;
    logic         bd;
  } in_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [4:0]   a3;
    logic [1:0]   tnew;
    logic [127:0] data;
    logic [4:0]   exc;
    logic         bd;
    logic [15:0]  cnt;
  } st_t;

  typedef struct {
    in_t         i;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [4:0]  ea3;
    logic [1:0]  et;
    logic [31:0] ew0;
    logic        ebd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur = '0;
  st_t  m0 = '0;
  st_t  m1 = '0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  logic         o0_valid, o1_valid, o0_bd, o1_bd;
  logic [31:0]  o0_pc, o1_pc, o0_instr, o1_instr;
  logic [4:0]   o0_a3, o1_a3, o0_exc, o1_exc;
  logic [1:0]   o0_tnew, o1_tnew;
  logic [127:0] o0_data, o1_data;
  logic [15:0]  o0_cnt, o1_cnt;

  pipe_stage_reg #(.DATA_W(32), .NUM_WORDS(4), .TNEW_W(2),
                   .AGE_ON_STALL(1), .KEEP_PC_ON_FLUSH(1)) dut0 (
    .clk(clk), .reset(rst_n), .stall(cur.stall), .flush(cur.flush),
    .in_valid(cur.valid), .in_pc(cur.pc), .in_instr(cur.instr),
    .in_a3(cur.a3), .in_tnew(cur.tnew), .in_data(cur.data),
    .in_exc(cur.exc), .in_bd(cur.bd),
    .out_valid(o0_valid), .out_pc(o0_pc), .out_instr(o0_instr),
    .out_a3(o0_a3), .out_tnew(o0_tnew), .out_data(o0_data),
    .out_exc(o0_exc), .out_bd(o0_bd), .bubble_cnt(o0_cnt));

  pipe_stage_reg #(.DATA_W(32), .NUM_WORDS(4), .TNEW_W(2),
                   .AGE_ON_STALL(0), .KEEP_PC_ON_FLUSH(0)) dut1 (
    .clk(clk), .reset(rst_n), .stall(cur.stall), .flush(cur.flush),
    .in_valid(cur.valid), .in_pc(cur.pc), .in_instr(cur.instr),
    .in_a3(cur.a3), .in_tnew(cur.tnew), .in_data(cur.data),
    .in_exc(cur.exc), .in_bd(cur.bd),
    .out_valid(o1_valid), .out_pc(o1_pc), .out_instr(o1_instr),
    .out_a3(o1_a3), .out_tnew(o1_tnew), .out_data(o1_data),
    .out_exc(o1_exc), .out_bd(o1_bd), .bubble_cnt(o1_cnt));

  // Reference behaviour of one stage for one clock edge.
  function automatic st_t step(input st_t s, input in_t i, input bit age, input bit keep);
    st_t n;
    n = s;
    if (i.flush) begin
      n = '0;
      if (keep) begin
        n.pc = i.pc;
        n.bd = i.bd;
      end
    end else if (i.stall) begin
      if (age && s.tnew > 0) n.tnew = s.tnew - 2'd1;
    end else begin
      n.valid = i.valid;
      n.pc    = i.pc;
      n.instr = i.instr;
      n.data  = i.data;
      n.exc   = i.exc;
      n.bd    = i.bd;
      n.a3    = i.valid ? i.a3 : 5'd0;
      n.tnew  = (i.valid && i.tnew > 0) ? i.tnew - 2'd1 : 2'd0;
    end
    n.cnt = s.cnt;
    if (!s.valid && s.cnt < 16'hFFFF) n.cnt = s.cnt + 16'd1;
    return n;
  endfunction

  function automatic in_t mk(input logic v, input logic st, input logic fl,
                             input logic [31:0] pc, input logic [4:0] a3,
                             input logic [1:0] t, input logic [31:0] w0,
                             input logic bd);
    in_t x;
    x = '0;
    x.valid = v; x.stall = st; x.flush = fl; x.pc = pc; x.a3 = a3;
    x.tnew = t; x.bd = bd; x.exc = 5'd4;
    x.instr = pc ^ 32'h0C00_0000;
    x.data = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, w0};
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_models();
    cmp("d0.valid", 128'(o0_valid), 128'(m0.valid));
    cmp("d0.pc",    128'(o0_pc),    128'(m0.pc));
    cmp("d0.instr", 128'(o0_instr), 128'(m0.instr));
    cmp("d0.a3",    128'(o0_a3),    128'(m0.a3));
    cmp("d0.tnew",  128'(o0_tnew),  128'(m0.tnew));
    cmp("d0.data",  o0_data,        m0.data);
    cmp("d0.exc",   128'(o0_exc),   128'(m0.exc));
    cmp("d0.bd",    128'(o0_bd),    128'(m0.bd));
    cmp("d0.cnt",   128'(o0_cnt),   128'(m0.cnt));
    cmp("d1.valid", 128'(o1_valid), 128'(m1.valid));
    cmp("d1.pc",    128'(o1_pc),    128'(m1.pc));
    cmp("d1.instr", 128'(o1_instr), 128'(m1.instr));
    cmp("d1.a3",    128'(o1_a3),    128'(m1.a3));
    cmp("d1.tnew",  128'(o1_tnew),  128'(m1.tnew));
    cmp("d1.data",  o1_data,        m1.data);
    cmp("d1.exc",   128'(o1_exc),   128'(m1.exc));
    cmp("d1.bd",    128'(o1_bd),    128'(m1.bd));
    cmp("d1.cnt",   128'(o1_cnt),   128'(m1.cnt));
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, ".d0"}, {o0_valid, o0_pc, o0_instr, o0_a3, o0_tnew, o0_exc, o0_bd, o0_cnt}, '0);
    cmp({nm, ".d0data"}, o0_data, '0);
    cmp({nm, ".d1"}, {o1_valid, o1_pc, o1_instr, o1_a3, o1_tnew, o1_exc, o1_bd, o1_cnt}, '0);
    cmp({nm, ".d1data"}, o1_data, '0);
  endtask

  // One rising edge; models advance only when reset is released.
  task automatic tick();
    st_t n0, n1;
    n0 = step(m0, cur, 1'b1, 1'b1);
    n1 = step(m1, cur, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if (rst_n) begin
      m0 = n0;
      m1 = n1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0 = '0;
    m1 = '0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[6];
  logic [31:0] held_pc;

  initial begin
    tbl[0] = '{mk(1,0,0,32'h3000,5'd5,2'd2,32'hDEADBEEF,0), 1, 32'h3000, 32'h0C003000, 5'd5, 2'd1, 32'hDEADBEEF, 0};
    tbl[1] = '{mk(1,0,0,32'h3004,5'd3,2'd0,32'h0000_0001,1), 1, 32'h3004, 32'h0C003004, 5'd3, 2'd0, 32'h0000_0001, 1};
    tbl[2] = '{mk(1,0,0,32'hBFC0_0000,5'd31,2'd3,32'hFFFF_FFFF,0), 1, 32'hBFC0_0000, 32'hB3C0_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 0};
    tbl[3] = '{mk(0,0,0,32'h3008,5'd7,2'd2,32'h1234_5678,0), 0, 32'h3008, 32'h0C003008, 5'd0, 2'd0, 32'h1234_5678, 0};
    tbl[4] = '{mk(1,1,1,32'h3010,5'd9,2'd3,32'hCAFE_F00D,1), 0, 32'h3010, 32'h0, 5'd0, 2'd0, 32'h0, 1};
    tbl[5] = '{mk(1,0,1,32'h3014,5'd2,2'd1,32'hAAAA_5555,0), 0, 32'h3014, 32'h0, 5'd0, 2'd0, 32'h0, 0};

    // Reset holds everything at 0 even with edges and active controls.
    #1;
    check_zero("por");
    cur = mk(1,0,0,32'h4000,5'd1,2'd2,32'h5,1);
    tick();
    check_zero("rst_load");
    cur.flush = 1'b1;
    tick();
    check_zero("rst_flush");
    cur = mk(1,0,0,32'h3000,5'd5,2'd2,32'hDEADBEEF,0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cmp("first_load.valid", 128'(o0_valid), 128'(1));
    check_models();

    // Table vectors: one edge each, expectations for the default instance.
    for (int k = 0; k < 6; k++) begin
      cur = tbl[k].i;
      tick();
      cmp($sformatf("tbl%0d.valid", k), 128'(o0_valid), 128'(tbl[k].ev));
      cmp($sformatf("tbl%0d.pc", k),    128'(o0_pc),    128'(tbl[k].epc));
      cmp($sformatf("tbl%0d.instr", k), 128'(o0_instr), 128'(tbl[k].einstr));
      cmp($sformatf("tbl%0d.a3", k),    128'(o0_a3),    128'(tbl[k].ea3));
      cmp($sformatf("tbl%0d.tnew", k),  128'(o0_tnew),  128'(tbl[k].et));
      cmp($sformatf("tbl%0d.w0", k),    128'(o0_data[31:0]), 128'(tbl[k].ew0));
      cmp($sformatf("tbl%0d.bd", k),    128'(o0_bd),    128'(tbl[k].ebd));
      check_models();
    end
    // Flush+stall on the no-keep instance clears PC and BD.
    cur = mk(1,1,1,32'h3010,5'd9,2'd3,32'h1,1);
    tick();
    cmp("flush_nokeep.pc", 128'(o1_pc), 128'(0));
    cmp("flush_nokeep.bd", 128'(o1_bd), 128'(0));
    cmp("flush_keep.pc",   128'(o0_pc), 128'(32'h3010));

    // Tnew ages while stalled (default) or holds (AGE_ON_STALL=0).
    cur = mk(1,0,0,32'h3020,5'd6,2'd2,32'h7777,0);
    tick();
    cmp("age.t0", 128'(o0_tnew), 128'(1));
    for (int k = 0; k < 3; k++) begin
      cur = mk(1,1,0,32'h9000 + 32'(k),5'd11,2'd3,32'h9999,1);
      tick();
      cmp($sformatf("age.stall%0d.tnew", k), 128'(o0_tnew), 128'(0));
      cmp($sformatf("age.stall%0d.pc", k), 128'(o0_pc), 128'(32'h3020));
      cmp($sformatf("age.stall%0d.w0", k), 128'(o0_data[31:0]), 128'(32'h7777));
      cmp($sformatf("hold.stall%0d.tnew", k), 128'(o1_tnew), 128'(1));
      check_models();
    end

    // Asynchronous reset in mid-stall, released between edges.
    #3;
    rst_n = 1'b0;
    m0 = '0;
    m1 = '0;
    #1;
    check_zero("async_rst");
    #2;
    rst_n = 1'b1;
    cur = mk(1,0,0,32'h3040,5'd8,2'd1,32'h4444,0);
    tick();
    cmp("post_rst.valid", 128'(o0_valid), 128'(1));
    cmp("post_rst.pc", 128'(o0_pc), 128'(32'h3040));
    check_models();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      cur.valid = ($urandom_range(3) != 0);
      cur.stall = ($urandom_range(3) == 0);
      cur.flush = ($urandom_range(7) == 0);
      cur.pc    = $urandom;
      cur.instr = $urandom;
      cur.a3    = 5'($urandom);
      cur.tnew  = 2'($urandom);
      cur.data  = {$urandom, $urandom, $urandom, $urandom};
      cur.exc   = 5'($urandom);
      cur.bd    = 1'($urandom);
      tick();
      check_models();
    end

    // Bubble counter saturation.
    do_reset();
    cur = mk(0,0,0,32'h0,5'd7,2'd2,32'h0,0);
    for (int k = 0; k < 65534; k++) tick();
    cmp("sat.preload", 128'(o0_cnt), 128'(16'hFFFE));
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp($sformatf("sat.%0d", k), 128'(o0_cnt), 128'(16'hFFFF));
      check_models();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
